// File: rtl/bias_fetch_pkg.sv
// Shared types and constants for the bias fetch sequencer and its skid buffer.
package bias_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SKID_DEPTH = 2;
    localparam int CNT_W      = $clog2(SKID_DEPTH + 1);
    localparam int PTR_W      = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

endpackage

// File: rtl/bias_fetch_ctrl_if.sv
// ROM read port and outgoing bias stream of the bias fetch sequencer.
interface bias_fetch_ctrl_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 8,
    parameter int CH_W   = 9
);
    logic              rom_read_enable;
    logic [ADDR_W-1:0] rom_addr;
    logic [WIDTH-1:0]  rom_data;
    logic              bias_valid;
    logic              bias_ready;
    logic [WIDTH-1:0]  bias_data;
    logic [CH_W-1:0]   bias_ch;
    logic              bias_last;

    modport master (
        output rom_read_enable,
        output rom_addr,
        input  rom_data,
        output bias_valid,
        input  bias_ready,
        output bias_data,
        output bias_ch,
        output bias_last
    );

    modport slave (
        input  rom_read_enable,
        input  rom_addr,
        output rom_data,
        input  bias_valid,
        output bias_ready,
        input  bias_data,
        input  bias_ch,
        input  bias_last
    );
endinterface

// File: rtl/bias_skid_fifo.sv
// Two-entry skid FIFO of {data, ch, last}; an empty FIFO passes the pushed
// word straight to its output so ROM data can be consumed in its arrival cycle.
module bias_skid_fifo
    import bias_fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CH_W  = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic [CH_W-1:0]  i_push_ch,
    input  logic             i_push_last,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CH_W-1:0]  o_ch,
    output logic             o_last,
    output logic [CNT_W-1:0] o_count,
    output logic [CNT_W-1:0] o_count_next
);

    logic [WIDTH-1:0] r_data [SKID_DEPTH];
    logic [CH_W-1:0]  r_ch   [SKID_DEPTH];
    logic             r_last [SKID_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_bypass;
    logic w_wr;
    logic w_rd;

    assign w_empty  = (r_count == '0);
    // Push and pop on an empty FIFO: the word goes straight through, nothing stored.
    assign w_bypass = w_empty && i_push && i_pop;
    assign w_wr     = i_push && !w_bypass && !i_flush;
    assign w_rd     = i_pop && !w_empty && !i_flush;

    always_comb begin
        o_count_next = r_count;
        if (i_flush) begin
            o_count_next = '0;
        end else if (w_wr && !w_rd) begin
            o_count_next = r_count + CNT_W'(1);
        end else if (!w_wr && w_rd) begin
            o_count_next = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= o_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_data[r_wr_ptr] <= i_push_data;
            r_ch[r_wr_ptr]   <= i_push_ch;
            r_last[r_wr_ptr] <= i_push_last;
        end
    end

    assign o_valid = !w_empty || i_push;
    assign o_data  = !w_empty ? r_data[r_rd_ptr] : (i_push ? i_push_data : '0);
    assign o_ch    = !w_empty ? r_ch[r_rd_ptr]   : (i_push ? i_push_ch   : '0);
    assign o_last  = !w_empty ? r_last[r_rd_ptr] : (i_push && i_push_last);
    assign o_count = r_count;

endmodule

// File: rtl/bias_fetch_ctrl.sv
// Streams one layer's bias words from the synchronous bias ROM onto a valid/ready
// stream. Optional range check on start enabled by BIAS_FETCH_ADDR_CHECK_EN.
module bias_fetch_ctrl
    import bias_fetch_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 256,
    parameter  int MAX_CH = 256,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int CH_W   = $clog2(MAX_CH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CH_W-1:0]   num_channels,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    bias_fetch_ctrl_if.master bus
);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_base;
    logic [CH_W-1:0]   r_num;
    logic [CH_W-1:0]   r_issued;
    logic              r_inflight;
    logic [CH_W-1:0]   r_inflight_ch;

    logic                     w_abort;
    logic                     w_pop;
    logic                     w_issue;
    logic                     w_last_issue;
    logic                     w_range_err;
    logic                     w_push_last;
    logic [CNT_W-1:0]         w_count;
    logic [CNT_W-1:0]         w_count_next;
    logic [CNT_W:0]           w_occ;
    logic [ADDR_W+CH_W-1:0]   w_addr_full;

    assign w_abort = abort && ((r_state == FETCH) || (r_state == DRAIN));
    assign w_pop   = bus.bias_valid && bus.bias_ready && !w_abort;

    // Occupancy once this cycle's pop is taken out; the in-flight word lands this cycle.
    assign w_occ = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight} - {{CNT_W{1'b0}}, w_pop};

    assign w_issue = (r_state == FETCH) && !w_abort && (r_issued != r_num)
                   && (w_occ < (CNT_W + 1)'(SKID_DEPTH));
    assign w_last_issue = w_issue && ((r_issued + CH_W'(1)) == r_num);

    assign w_addr_full = {{CH_W{1'b0}}, r_base} + {{ADDR_W{1'b0}}, r_issued};
    assign w_push_last = (r_inflight_ch == (r_num - CH_W'(1)));

`ifdef BIAS_FETCH_ADDR_CHECK_EN
    logic [ADDR_W+CH_W:0] w_end;
    logic                 r_err;

    assign w_end = {{(CH_W + 1){1'b0}}, base_addr} + {{(ADDR_W + 1){1'b0}}, num_channels};
    assign w_range_err = (w_end > (ADDR_W + CH_W + 1)'(DEPTH))
                      || (num_channels > CH_W'(MAX_CH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (r_state == IDLE) && start && w_range_err;
        end
    end

    assign err = r_err;
`else
    assign w_range_err = 1'b0;
    assign err         = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_range_err || (num_channels == '0)) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = FETCH;
                    end
                end
            end
            FETCH: begin
                if (w_abort) begin
                    w_state_next = DONE;
                end else if (w_last_issue) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Finish as soon as the final beat leaves, not a cycle later.
                if (w_abort || (w_count_next == '0)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_base        <= '0;
            r_num         <= '0;
            r_issued      <= '0;
            r_inflight    <= 1'b0;
            r_inflight_ch <= '0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_issue;
            if ((r_state == IDLE) && start) begin
                r_base   <= base_addr;
                r_num    <= num_channels;
                r_issued <= '0;
            end else if (w_issue) begin
                r_issued <= r_issued + CH_W'(1);
            end
            if (w_issue) begin
                r_inflight_ch <= r_issued;
            end
        end
    end

    bias_skid_fifo #(
        .WIDTH (WIDTH),
        .CH_W  (CH_W)
    ) u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (w_abort),
        .i_push       (r_inflight),
        .i_push_data  (bus.rom_data),
        .i_push_ch    (r_inflight_ch),
        .i_push_last  (w_push_last),
        .i_pop        (w_pop),
        .o_valid      (bus.bias_valid),
        .o_data       (bus.bias_data),
        .o_ch         (bus.bias_ch),
        .o_last       (bus.bias_last),
        .o_count      (w_count),
        .o_count_next (w_count_next)
    );

    assign busy                = (r_state != IDLE);
    assign done                = (r_state == DONE);
    assign bus.rom_read_enable = w_issue;
    assign bus.rom_addr        = w_issue ? w_addr_full[ADDR_W-1:0] : '0;

endmodule

// File: tb/tb_bias_fetch_ctrl.sv
// Directed bench for bias_fetch_ctrl: ROM model, beat/address scoreboards and
// a negedge monitor checking stream order, stall stability and read occupancy.
module tb_bias_fetch_ctrl;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 256;
    localparam int MAX_CH = 256;
    localparam int ADDR_W = 8;
    localparam int CH_W   = 9;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [CH_W-1:0]  ch;
        logic             last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CH_W-1:0]   num_channels = '0;
    logic              busy;
    logic              done;
    logic              err;

    bias_fetch_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CH_W(CH_W)) bus ();

    bias_fetch_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_CH(MAX_CH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .num_channels (num_channels),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] rom [DEPTH];
    logic [WIDTH-1:0] rom_q = '0;

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = WIDTH'(i + 100);
    end

    always @(posedge clk) rom_q <= bus.rom_read_enable ? rom[bus.rom_addr] : '0;
    assign bus.rom_data = rom_q;

    beat_t             exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    int n_chk = 0;
    int n_err = 0;
    int n_rd = 0;
    int n_xfer = 0;
    int cyc = 0;
    int last_xfer_cyc = -10;

    task automatic checkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checkv(tag, 64'(obs), 64'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [ADDR_W-1:0] base, input int n);
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = ADDR_W'(int'(base) + i);
            addr_q.push_back(a);
            exp_q.push_back('{data: rom[a], ch: CH_W'(i), last: (i == n - 1)});
        end
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] base, input int n);
        n_rd         = 0;
        n_xfer       = 0;
        base_addr    = base;
        num_channels = CH_W'(n);
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1 repeating
    task automatic wait_done(input int mode, input bit chk_timing);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (mode == 1) bus.bias_ready = ((i % 4) == 0) || ((i % 4) == 3);
            else           bus.bias_ready = 1'b1;
            tick();
            if (done) got = 1'b1;
        end
        bus.bias_ready = 1'b1;
        check1("done_seen", got, 1'b1);
        if (chk_timing) checkv("done_after_last", 64'(cyc), 64'(last_xfer_cyc + 1));
        check1("done_busy", busy, 1'b1);
        check1("done_no_err", err, 1'b0);
        tick();
        check1("done_one_cycle", done, 1'b0);
        check1("idle_busy", busy, 1'b0);
        checkv("beats_left", 64'(exp_q.size()), 64'd0);
        checkv("reads_left", 64'(addr_q.size()), 64'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Stream and ROM-port monitor, sampled on the falling edge.
    initial begin
        beat_t b;
        beat_t e;
        beat_t prev_beat;
        logic [ADDR_W-1:0] ea;
        bit prev_stall;
        bit prev_abort;
        prev_stall = 1'b0;
        prev_abort = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                b = '{data: bus.bias_data, ch: bus.bias_ch, last: bus.bias_last};
                if (prev_stall && !prev_abort) begin
                    check1("stall_valid", bus.bias_valid, 1'b1);
                    checkv("stall_beat", 64'(b), 64'(prev_beat));
                end
                if (bus.bias_valid && bus.bias_ready && !abort) begin
                    check1("beat_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        checkv("beat", 64'(b), 64'(e));
                    end
                    $display("beat cyc=%0d ch=%0d data=%0d last=%0d", cyc, b.ch, b.data, b.last);
                    n_xfer++;
                    if (b.last) last_xfer_cyc = cyc;
                end
                if (bus.rom_read_enable) begin
                    check1("read_occupancy", (n_rd - n_xfer) < 2, 1'b1);
                    check1("read_expected", addr_q.size() != 0, 1'b1);
                    if (addr_q.size() != 0) begin
                        ea = addr_q.pop_front();
                        checkv("rom_addr", 64'(bus.rom_addr), 64'(ea));
                    end
                    n_rd++;
                end
                prev_stall = bus.bias_valid && !bus.bias_ready;
                prev_abort = abort;
                prev_beat  = b;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit hit;
        bus.bias_ready = 1'b1;
        #1;
        // reset values
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_rd_en", bus.rom_read_enable, 1'b0);
        checkv("rst_addr", 64'(bus.rom_addr), 64'd0);
        check1("rst_valid", bus.bias_valid, 1'b0);
        checkv("rst_data", 64'(bus.bias_data), 64'd0);
        checkv("rst_ch", 64'(bus.bias_ch), 64'd0);
        check1("rst_last", bus.bias_last, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // job 1: base 10, N=4, ready high, latency check
        push_job(8'd10, 4);
        pulse_start(8'd10, 4);
        check1("start_busy", busy, 1'b1);
        check1("valid_not_early", bus.bias_valid, 1'b0);
        check1("first_read_en", bus.rom_read_enable, 1'b1);
        tick();
        check1("first_valid", bus.bias_valid, 1'b1);
        checkv("first_data", 64'(bus.bias_data), 64'd110);
        wait_done(0, 1'b1);

        // job 2: same, with ready toggling
        push_job(8'd10, 4);
        pulse_start(8'd10, 4);
        wait_done(1, 1'b1);

        // job 3: zero length
        pulse_start(8'd0, 0);
        check1("zero_done", done, 1'b1);
        check1("zero_busy", busy, 1'b1);
        check1("zero_valid", bus.bias_valid, 1'b0);
        tick();
        check1("zero_done_clear", done, 1'b0);
        check1("zero_idle", busy, 1'b0);
        checkv("zero_reads", 64'(n_rd), 64'd0);

        // job 4: range crossing the top of the ROM
`ifdef BIAS_FETCH_ADDR_CHECK_EN
        pulse_start(8'd254, 4);
        check1("range_err", err, 1'b1);
        check1("range_done", done, 1'b1);
        check1("range_busy", busy, 1'b1);
        tick();
        check1("range_err_clear", err, 1'b0);
        check1("range_idle", busy, 1'b0);
        checkv("range_reads", 64'(n_rd), 64'd0);
`else
        push_job(8'd254, 4);
        pulse_start(8'd254, 4);
        wait_done(0, 1'b1);
`endif

        // job 5: abort after the second beat, with the stream stalled
        push_job(8'd10, 4);
        pulse_start(8'd10, 4);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            if (n_xfer >= 2) hit = 1'b1;
        end
        check1("abort_two_beats", hit, 1'b1);
        bus.bias_ready = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check1("abort_valid_low", bus.bias_valid, 1'b0);
        check1("abort_done", done, 1'b1);
        exp_q.delete();
        addr_q.delete();
        tick();
        check1("abort_done_clear", done, 1'b0);
        check1("abort_idle", busy, 1'b0);
        bus.bias_ready = 1'b1;
        push_job(8'd0, 2);
        pulse_start(8'd0, 2);
        wait_done(0, 1'b1);

        // job 6: asynchronous reset in the middle of FETCH
        push_job(8'd0, 8);
        pulse_start(8'd0, 8);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check1("mid_rst_busy", busy, 1'b0);
        check1("mid_rst_rd_en", bus.rom_read_enable, 1'b0);
        checkv("mid_rst_addr", 64'(bus.rom_addr), 64'd0);
        check1("mid_rst_valid", bus.bias_valid, 1'b0);
        checkv("mid_rst_data", 64'(bus.bias_data), 64'd0);
        check1("mid_rst_done", done, 1'b0);
        exp_q.delete();
        addr_q.delete();
        tick();
        tick();
        check1("rst_hold_done", done, 1'b0);
        rst_n = 1'b1;
        tick();
        push_job(8'd20, 3);
        pulse_start(8'd20, 3);
        wait_done(1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
